proj_sweep_eval: RTL
====================

PROJ_SWEEP_EVAL -- requirements
Module: proj_sweep_eval

Interface
REQ-001 The block SHALL have parameter SIG_POLY, default 16'h1021, the CRC-16 feedback polynomial for the output signature.
REQ-002 The block SHALL have parameter SIG_SEED, default 16'hFFFF, the signature value loaded at sweep start.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request one full input sweep.
REQ-005 The block SHALL have port x, output, 8 bits: registered input vector driven to the downstream 8-input projection function (x[0] to x0 through x[7] to x7).
REQ-006 The block SHALL have port y0, input, 1 bit: combinational response of the function to x, sampled in the same cycle.
REQ-007 The block SHALL have port expected_sig, input, 16 bits: golden signature used for comparison.
REQ-008 The block SHALL have port busy, output, 1 bit: sweep in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse at sweep completion.
REQ-010 The block SHALL have port onset_cnt, output, 9 bits: number of vectors with y0=1, range 0..256.
REQ-011 The block SHALL have port signature, output, 16 bits: CRC over the 256 y0 samples, taken in ascending x order.
REQ-012 The block SHALL have port match, output, 1 bit: signature equals expected_sig at completion.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SWEEP and DONE.
REQ-014 In IDLE with start=1 at a clock edge, the block SHALL go to SWEEP and set x=0, signature=SIG_SEED, onset_cnt=0 and match=0.
REQ-015 In SWEEP, on each edge, the block SHALL sample y0 for the current x and apply both updates below.
 - signature update: signature <= {signature[14:0],1'b0} ^ (signature[15]^y0 ? SIG_POLY : 0).
 - onset update: onset_cnt <= onset_cnt + y0.
REQ-016 In SWEEP with x<255, x SHALL increment by 1 each cycle.
REQ-017 In SWEEP at x=255, the block SHALL take the last sample, go to DONE and hold x at 255; x SHALL never wrap to 0 inside a sweep.
REQ-018 In SWEEP, busy SHALL be 1; busy SHALL be 0 in IDLE and DONE.
REQ-019 The SWEEP state SHALL last exactly 256 cycles, one per vector, with no skipped or repeated vector.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE unconditionally.
REQ-021 match SHALL be registered on the SWEEP-to-DONE edge from the final signature next-value compared to expected_sig.
REQ-022 match SHALL be valid from the done cycle onward and held until the next accepted start.
REQ-023 onset_cnt, signature, match and x SHALL hold their values in IDLE and DONE until the next accepted start.
REQ-024 start SHALL be ignored in SWEEP and DONE, with no restart and no queuing; start held high continuously SHALL give back-to-back sweeps with one IDLE cycle between done and the next SWEEP.
REQ-025 Latency SHALL be as follows: start sampled at edge T, first y0 sample at edge T+1, last sample at edge T+256, done high in cycle T+256..T+257, IDLE from edge T+257.
REQ-026 onset_cnt SHALL be 9 bits wide so that 256 fits without overflow; no saturation logic is required.
REQ-027 y0 SHALL meet setup to clk within one cycle of x changing, since the downstream function is purely combinational; the block SHALL add no further pipelining.

Reset
REQ-028 rst_n=0 SHALL act immediately, regardless of clock, and set state to IDLE and all of the following outputs.
 - x=0, busy=0, done=0, onset_cnt=0.
 - signature=SIG_SEED, match=0.
REQ-029 Reset asserted mid-SWEEP SHALL abort the sweep with no done pulse, and all results SHALL return to reset values.
REQ-030 After rst_n deasserts, the first start SHALL be accepted at the first rising edge at which it is sampled high.

Verification
REQ-031 The bench SHALL cover y0 tied to 0 with one start: busy high 256 cycles, a single done pulse, onset_cnt=0, signature equal to the software CRC model of 256 zeros from 16'hFFFF.
REQ-032 The bench SHALL cover y0 tied to 1: onset_cnt=256 (9'h100), with signature and match checked against the model, with expected_sig set to the model value giving match=1 and model^1 giving match=0.
REQ-033 The bench SHALL cover y0=x[0]: onset_cnt=128, and x SHALL observably step 0,1,...,255 with no gaps and hold at 255 after done.
REQ-034 The bench SHALL cover y0 driven by a golden behavioural model of the 8-input projection function: onset_cnt and signature SHALL equal the model's values, and match=1.
REQ-035 The bench SHALL cover start pulsed again at sweep cycle 100 and in the DONE cycle: both ignored, sweep length still 256 cycles, exactly one done pulse.
REQ-036 The bench SHALL cover rst_n asserted at sweep cycle 50 between clock edges: outputs at reset values immediately with no done pulse; a new start then gives a full, correct sweep.

Source files
------------

// File: rtl/proj_sweep_eval.sv
// Exhaustive sweep of an 8-input combinational function: drives every x in
// ascending order, counts the onset and builds a CRC-16 signature of y0.
module proj_sweep_eval #(
  parameter logic [15:0] SIG_POLY = 16'h1021,
  parameter logic [15:0] SIG_SEED = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  x,
  input  logic        y0,
  input  logic [15:0] expected_sig,
  output logic        busy,
  output logic        done,
  output logic [8:0]  onset_cnt,
  output logic [15:0] signature,
  output logic        match
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] sig_next;

  // y0 belongs to the current x, so it folds into the signature on this edge
  assign sig_next = {signature[14:0], 1'b0} ^ ((signature[15] ^ y0) ? SIG_POLY : 16'h0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SWEEP;
      end
      SWEEP: begin
        busy = 1'b1;
        if (x == 8'hFF) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= 8'h00;
      signature <= SIG_SEED;
      onset_cnt <= 9'd0;
      match     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x         <= 8'h00;
            signature <= SIG_SEED;
            onset_cnt <= 9'd0;
            match     <= 1'b0;
          end
        end
        SWEEP: begin
          signature <= sig_next;
          onset_cnt <= onset_cnt + {8'd0, y0};
          // x parks at 255 on the final sample instead of wrapping
          if (x != 8'hFF) x <= x + 8'd1;
          else            match <= (sig_next == expected_sig);
        end
        default: ;
      endcase
    end
  end

endmodule
